// File: rtl/aes_sbox_sched.sv
// ---------------------------------------------------------------------------
// aes_sbox_sched
//
// Purpose:
//   Time-shares one external combinational 32-bit S-box between two users:
//   a 128-bit SubBytes request (processed one 32-bit word per cycle) and
//   single-word key-expansion lookups. Key-expansion traffic has priority
//   in RUN, but it can win at most two cycles in a row. This guarantees
//   that the state request always makes progress.
//
// Ports:
//   clk           - single clock, rising edge
//   rst           - synchronous active-high reset
//   st_valid      - 128-bit state request present
//   st_data       - state to substitute (word0 = [127:96] ... word3 = [31:0])
//   st_ready      - state request accepted when st_valid & st_ready
//   st_out_valid  - one-cycle pulse, st_out_data holds the SubBytes result
//   st_out_data   - SubBytes result, same word order as st_data
//   kx_valid      - key-expansion word request present
//   kx_word       - key-expansion word to substitute
//   kx_ready      - kx request granted when kx_valid & kx_ready
//   kx_out_valid  - one-cycle pulse, one cycle after a kx grant
//   kx_out_word   - substituted key word
//   sbox_in       - word driven to the shared S-box (0 when unused)
//   sbox_out      - same-cycle S-box result for sbox_in
//   busy          - high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module aes_sbox_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  input  logic [127:0] st_data,
  output logic         st_ready,
  output logic         st_out_valid,
  output logic [127:0] st_out_data,
  input  logic         kx_valid,
  input  logic [31:0]  kx_word,
  output logic         kx_ready,
  output logic         kx_out_valid,
  output logic [31:0]  kx_out_word,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [127:0]  st_reg;
  logic [127:0]  result;
  logic [1:0]    wc;
  logic [1:0]    kx_streak;
  logic [31:0]  st_word;
  logic          kx_grant;
  logic          st_accept;
  logic          run_serve;

  // Handshake and status outputs. Reset forces every ready, busy and the
  // done pulse low. This prevents a handshake from completing in a cycle
  // whose state is about to be thrown away.
  always_comb begin
    st_ready     = 1'b0;
    kx_ready     = 1'b0;
    st_out_valid = 1'b0;
    busy         = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          st_ready = 1'b1;
          kx_ready = 1'b1;
        end
        RUN: begin
          kx_ready = (kx_streak < 2'd2);
        end
        DONE: begin
          kx_ready     = 1'b1;
          st_out_valid = 1'b1;
        end
        default: begin
          st_ready = 1'b0;
        end
      endcase
    end
  end

  assign kx_grant  = kx_valid & kx_ready;
  assign st_accept = st_valid & st_ready;

  // A RUN cycle belongs to the state word unless key expansion took it.
  assign run_serve = (state == RUN) & ~rst & ~kx_grant;

  // Select the state word addressed by the word counter.
  always_comb begin
    st_word = st_reg[127:96];
    case (wc)
      2'd0: st_word = st_reg[127:96];
      2'd1: st_word = st_reg[95:64];
      2'd2: st_word = st_reg[63:32];
      2'd3: st_word = st_reg[31:0];
      default: st_word = st_reg[127:96];
    endcase
  end

  // Shared S-box input mux. A kx grant wins. Otherwise a RUN cycle
  // feeds the current state word. In all other cases the bus is driven
  // to zero, so an idle S-box sees a stable input.
  always_comb begin
    sbox_in = 32'd0;
    if (kx_grant) begin
      sbox_in = kx_word;
    end else if (run_serve) begin
      sbox_in = st_word;
    end
  end

  // Next-state logic. RUN leaves only on the cycle that actually writes
  // word 3. A stalled cycle with wc == 3 stays in RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (st_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!kx_grant && (wc == 2'd3)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath. This block captures the request, advances the word counter
  // and collects results. st_out_data is loaded together with the final
  // word. The result is therefore already visible in DONE, and it holds
  // until the next request completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_reg       <= 128'd0;
      result       <= 128'd0;
      wc           <= 2'd0;
      kx_streak    <= 2'd0;
      st_out_data  <= 128'd0;
      kx_out_valid <= 1'b0;
      kx_out_word  <= 32'd0;
    end else begin
      kx_out_valid <= kx_grant;
      if (kx_grant) begin
        kx_out_word <= sbox_out;
      end

      if (st_accept) begin
        st_reg <= st_data;
        wc     <= 2'd0;
      end

      // The streak counts back-to-back kx wins in RUN and saturates at 2.
      // This keeps kx_ready low for one cycle and lets the state word through.
      if (state == RUN) begin
        if (kx_grant) begin
          if (kx_streak != 2'd2) begin
            kx_streak <= kx_streak + 2'd1;
          end
        end else begin
          kx_streak <= 2'd0;
        end
      end else begin
        kx_streak <= 2'd0;
      end

      if (run_serve) begin
        wc <= wc + 2'd1;
        case (wc)
          2'd0: result[127:96] <= sbox_out;
          2'd1: result[95:64]  <= sbox_out;
          2'd2: result[63:32]  <= sbox_out;
          2'd3: begin
            result[31:0] <= sbox_out;
            st_out_data  <= {result[127:32], sbox_out};
          end
          default: result[127:96] <= sbox_out;
        endcase
      end
    end
  end

endmodule

// File: doc/aes_sbox_sched.md
AES_SBOX_SCHED -- requirements
Module: aes_sbox_sched

Interface
- REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-003 SHALL have port st_valid, input, 1 bit: 128-bit state request present.
- REQ-004 SHALL have port st_data, input, 128 bits: state to substitute; word0 = [127:96], word3 = [31:0].
- REQ-005 SHALL have port st_ready, output, 1 bit: state request accepted when st_valid & st_ready.
- REQ-006 SHALL have port st_out_valid, output, 1 bit: one-cycle pulse; st_out_data valid.
- REQ-007 SHALL have port st_out_data, output, 128 bits: SubBytes result, same word order as st_data.
- REQ-008 SHALL have port kx_valid, input, 1 bit: key-expansion word request present.
- REQ-009 SHALL have port kx_word, input, 32 bits: key-expansion word to substitute.
- REQ-010 SHALL have port kx_ready, output, 1 bit: kx request granted when kx_valid & kx_ready.
- REQ-011 SHALL have port kx_out_valid, output, 1 bit: one-cycle pulse; kx_out_word valid.
- REQ-012 SHALL have port kx_out_word, output, 32 bits: substituted key word.
- REQ-013 SHALL have port sbox_in, output, 32 bits: word driven to the shared combinational 32-bit S-box.
- REQ-014 SHALL have port sbox_out, input, 32 bits: same-cycle S-box result for sbox_in.
- REQ-015 SHALL have port busy, output, 1 bit: high whenever FSM is not IDLE.

Function
- REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
- REQ-017 IDLE: st_ready = 1; on st_valid, register st_data, clear word counter wc (2 bits) to 0, go RUN.
- REQ-018 RUN: per cycle the S-box serves exactly one requester, either a kx grant or state word wc.
- REQ-019 kx_ready SHALL be 1 in IDLE and DONE; in RUN it SHALL be 1 only while kx_streak < 2.
- REQ-020 On a kx grant: sbox_in = kx_word in that cycle; sbox_out registered to kx_out_word; kx_out_valid = 1 in the next cycle only (latency 1).
- REQ-021 A kx grant in RUN SHALL stall wc and increment kx_streak (2-bit, saturating at 2).
- REQ-022 RUN cycle without a kx grant: sbox_in = state word wc; sbox_out written to result word wc; kx_streak cleared to 0; wc increments.
- REQ-023 After word 3 is written (wc wraps 3->0), go DONE.
- REQ-024 DONE (one cycle): st_out_valid = 1, st_out_data = result; st_ready = 0; next state IDLE.
- REQ-025 kx_streak SHALL be 0 outside RUN.
- REQ-026 st_out_data and kx_out_word SHALL hold their last values between pulses.
- REQ-027 sbox_in SHALL be 0 when neither requester is served.
- REQ-028 Simultaneous st_valid and kx_valid in IDLE: both SHALL be accepted in the same cycle.
- REQ-029 State latency without kx traffic: accept in cycle N, RUN in N+1..N+4, st_out_valid in N+5; each kx grant in RUN adds one cycle.
- REQ-030 st_valid outside IDLE SHALL be ignored; no queuing of state requests.

Reset
- REQ-031 With rst high at a clock edge: FSM to IDLE; wc, kx_streak, result, st_out_data, kx_out_word to 0; st_out_valid, kx_out_valid to 0.
- REQ-032 While rst is high, st_ready and kx_ready SHALL be 0 and busy SHALL be 0.
- REQ-033 Reset during RUN or DONE SHALL discard the in-flight request; no st_out_valid pulse follows.

Verification
- REQ-034 Single state: st_data = {4{32'h00010203}} accepted at N -> st_out_valid at N+5 only, st_out_data = {4{32'h637c777b}}, busy high N+1..N+5.
- REQ-035 Single kx: kx_word = 32'h53525352 granted in IDLE at N -> kx_out_valid at N+1, kx_out_word = 32'hed00ed00.
- REQ-036 Continuous kx_valid through a state request accepted at N -> kx grant pattern 2 on / 1 off in RUN; st_out_valid at N+13; every kx result correct.
- REQ-037 Same-cycle st_valid and kx_valid in IDLE -> both accepted; kx_out_valid at N+1; st_out_valid at N+5.
- REQ-038 rst asserted at N+3 of a RUN -> next cycle IDLE with all outputs 0; no st_out_valid; a new request after reset completes normally.
- REQ-039 st_valid held high through DONE -> second request accepted in the first IDLE cycle after DONE, not during DONE.
